// File: rtl/comm_pkg.sv
// Shared definitions for the maze-runner command transmitter: FSM states and
// UART framing constants.
package comm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam int DEFAULT_BAUD_CNT = 2604;
  localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/comm_master_uart_tx.sv
// 8N1 byte transmitter: loads {stop, data, start} into a shift register and
// shifts it out LSB first, one bit every BAUD_CNT clocks.
module uart_tx
  import comm_pkg::*;
#(
  parameter int BAUD_CNT = DEFAULT_BAUD_CNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int BW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [9:0]    r_shift;
  logic          r_busy;
  logic          r_done;
  logic          w_baud_tc;

  assign w_baud_tc = r_busy && (r_baud == BW'(BAUD_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (trmt) begin
          r_shift <= {1'b1, tx_data, 1'b0};
          r_baud  <= '0;
          r_bit   <= '0;
          r_busy  <= 1'b1;
        end
      end else if (w_baud_tc) begin
        // Ones shift in from the top, so the line idles high once the stop bit is out.
        r_baud  <= '0;
        r_shift <= {1'b1, r_shift[9:1]};
        r_bit   <= r_bit + 4'd1;
        if (r_bit == 4'(FRAME_BITS - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else begin
        r_baud <= r_baud + BW'(1);
      end
    end
  end

  assign TX      = r_shift[0];
  assign tx_done = r_done;

endmodule

// File: rtl/comm_master.sv
// Sends a 16-bit command as two UART bytes, high byte first, and flags
// cmd_cmplt once both have left the line.
module comm_master
  import comm_pkg::*;
#(
  parameter int BAUD_CNT = DEFAULT_BAUD_CNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        TX,
  output logic        cmd_cmplt
);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_low_byte;
  logic       r_cmplt;
  logic       w_trmt;
  logic [7:0] w_tx_data;
  logic       w_capture;
  logic       w_set_cmplt;
  logic       w_tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_trmt       = 1'b0;
    w_tx_data    = cmd[15:8];
    w_capture    = 1'b0;
    w_set_cmplt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (snd_cmd) begin
          w_trmt       = 1'b1;
          w_capture    = 1'b1;
          w_state_next = HIGH;
        end
      end
      HIGH: begin
        if (w_tx_done) begin
          w_trmt       = 1'b1;
          w_tx_data    = r_low_byte;
          w_state_next = LOW;
        end
      end
      LOW: begin
        if (w_tx_done) begin
          w_set_cmplt  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The low byte is held locally so cmd may change once the word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low_byte <= '0;
      r_cmplt    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_low_byte <= cmd[7:0];
        r_cmplt    <= 1'b0;
      end else if (w_set_cmplt) begin
        r_cmplt <= 1'b1;
      end
    end
  end

  uart_tx #(
    .BAUD_CNT(BAUD_CNT)
  ) u_uart_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .trmt   (w_trmt),
    .tx_data(w_tx_data),
    .TX     (TX),
    .tx_done(w_tx_done)
  );

  assign cmd_cmplt = r_cmplt;

endmodule

// File: tb/tb_comm_master.sv
// Bench for comm_master: captures the TX line per word and checks it against a
// waveform built from the 8N1 framing rules plus a mid-bit receiver model.
module tb_comm_master;

  localparam int B    = 16;
  localparam int MAXL = 20 * B + 8;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd     = '0;
  logic        TX;
  logic        cmd_cmplt;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic smp[MAXL];
  int   n_smp;
  int   cmplt_idx;

  always #5 clk = ~clk;

  comm_master #(.BAUD_CNT(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .snd_cmd  (snd_cmd),
    .cmd      (cmd),
    .TX       (TX),
    .cmd_cmplt(cmd_cmplt)
  );

  // Receiver model: samples each data bit at its centre, frame starting at 'start'.
  function automatic logic [7:0] rx_byte(input int start);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      int idx = start + (k + 1) * B + B / 2;
      b[k] = (idx < n_smp) ? smp[idx] : 1'bx;
    end
    return b;
  endfunction

  // Issues one word, captures TX until cmd_cmplt rises and checks the result.
  // hold: cycles snd_cmd stays high; pulse_idx: extra one-cycle pulse; alt: cmd after capture.
  task automatic run_word(input logic [15:0] w, input int hold, input int pulse_idx,
                          input logic [15:0] alt, input string tag);
    logic exp_wave[$];
    int   gap;
    int   bad_idx;
    logic [7:0] hi_rx, lo_rx;
    logic [7:0] bytes[2];
    snd_cmd = 1'b1;
    cmd     = w;
    @(posedge clk);
    n_smp     = 0;
    cmplt_idx = -1;
    for (int i = 0; i < MAXL; i++) begin
      @(negedge clk);
      smp[i] = TX;
      n_smp  = i + 1;
      if (i == 0) begin
        n_cmp++;
        if (cmd_cmplt !== 1'b0) begin
          n_fail++;
          $display("FAIL %s cmplt_clear: got %b want 0", tag, cmd_cmplt);
        end
      end
      if (i > 0 && cmd_cmplt === 1'b1) begin
        cmplt_idx = i;
        break;
      end
      snd_cmd = (i + 1 < hold) || (i + 1 == pulse_idx);
      cmd     = alt;
    end
    snd_cmd = 1'b0;

    gap = (n_smp > 10 * B && smp[10 * B] === 1'b1) ? 1 : 0;
    bytes[0] = w[15:8];
    bytes[1] = w[7:0];
    for (int f = 0; f < 2; f++) begin
      if (f == 1 && gap == 1) exp_wave.push_back(1'b1);
      for (int k = 0; k < 10; k++) begin
        logic bitv;
        bitv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bytes[f][k - 1];
        for (int c = 0; c < B; c++) exp_wave.push_back(bitv);
      end
    end

    bad_idx = -1;
    for (int j = 0; j < exp_wave.size(); j++) begin
      if (j >= n_smp || smp[j] !== exp_wave[j]) begin
        bad_idx = j;
        break;
      end
    end
    if (bad_idx < 0) begin
      for (int j = exp_wave.size(); j < n_smp; j++) begin
        if (smp[j] !== 1'b1) begin
          bad_idx = j;
          break;
        end
      end
    end
    n_cmp++;
    if (bad_idx >= 0) begin
      n_fail++;
      $display("FAIL %s waveform: first bad sample %0d got %b want %b (captured %0d)", tag,
               bad_idx, (bad_idx < n_smp) ? smp[bad_idx] : 1'bx,
               (bad_idx < exp_wave.size()) ? exp_wave[bad_idx] : 1'b1, n_smp);
    end

    n_cmp++;
    if (cmplt_idx < exp_wave.size() || cmplt_idx > 20 * B + 2) begin
      n_fail++;
      $display("FAIL %s cmplt_timing: rose at %0d want %0d..%0d", tag, cmplt_idx,
               exp_wave.size(), 20 * B + 2);
    end

    hi_rx = rx_byte(0);
    lo_rx = rx_byte(10 * B + gap);
    n_cmp++;
    if ({hi_rx, lo_rx} !== w) begin
      n_fail++;
      $display("FAIL %s rx_decode: got %h want %h", tag, {hi_rx, lo_rx}, w);
    end
    $display("word %-10s cmd=%h rx=%h gap=%0d cmplt@%0d", tag, w, {hi_rx, lo_rx}, gap, cmplt_idx);
  endtask

  // Watches the line for 'cycles' clocks with no request and expects it quiet.
  task automatic check_quiet(input int cycles, input logic exp_cmplt, input string tag);
    int bad = -1;
    logic got_tx = 1'b1, got_c = exp_cmplt;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bad < 0 && (TX !== 1'b1 || cmd_cmplt !== exp_cmplt)) begin
        bad = i; got_tx = TX; got_c = cmd_cmplt;
      end
    end
    n_cmp++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: at cycle %0d TX=%b cmplt=%b want TX=1 cmplt=%b", tag, bad, got_tx,
               got_c, exp_cmplt);
    end
    $display("quiet %-10s %0d cycles checked", tag, cycles);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (TX !== 1'b1 || cmd_cmplt !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: TX=%b cmplt=%b want TX=1 cmplt=0", TX, cmd_cmplt);
      end
    end
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_idle();
    check_quiet(25 * B, 1'b0, "idle");
  endtask

  task automatic test_patterns();
    run_word(16'hAAAA, 1, -1, 16'hAAAA, "aaaa");
    run_word(16'h0003, 1, -1, 16'h0003, "0003");
    for (int i = 0; i < 4; i++) begin
      logic [15:0] w, a;
      w = 16'($urandom);
      a = 16'($urandom);
      run_word(w, 1, -1, a, "random");
    end
  endtask

  task automatic test_hold();
    logic [15:0] w, a;
    w = 16'($urandom);
    a = ~w;
    run_word(w, 2, 5 * B, a, "hold");
    check_quiet(25 * B, 1'b1, "no_retrig");
  endtask

  task automatic test_back_to_back();
    run_word(16'($urandom), 1, -1, 16'h0000, "b2b_first");
    run_word(16'($urandom), 1, -1, 16'hFFFF, "b2b_second");
    run_word(16'h00FF, 1, -1, 16'h1234, "b2b_third");
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    w = {8'($urandom), 8'h00};
    @(negedge clk);
    snd_cmd = 1'b1;
    cmd     = w;
    @(posedge clk);
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (15 * B) @(negedge clk);
    n_cmp++;
    if (TX !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_tx: got %b want 0", TX);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (TX !== 1'b1 || cmd_cmplt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: TX=%b cmplt=%b want TX=1 cmplt=0", TX, cmd_cmplt);
    end
    $display("reset mid-word cmd=%h TX=%b cmplt=%b", w, TX, cmd_cmplt);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_quiet(25 * B, 1'b0, "no_resume");
    run_word(16'($urandom), 1, -1, 16'h5A5A, "post_reset");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_patterns();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/comm_master.md
# comm_master

Command transmitter for the maze-runner system. It accepts a 16-bit travel-plan command word and serialises it onto a single UART line as two 8N1 bytes, high byte first. The line feeds the robot's UART receiver, so a bench or host controller can issue commands such as 16'hAAAA or 16'h0003. `cmd_cmplt` tells the issuer when the whole word has left the line.

## Interface
- `BAUD_CNT`, default 2604: clocks per UART bit (50 MHz / 19200 baud).
- `clk`  in  1: single system clock; all logic on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `snd_cmd`  in  1: request to transmit `cmd`; sampled on posedge.
- `cmd`  in  16: command word; captured on the accepted `snd_cmd` edge.
- `TX`  out  1: UART serial output; idles high.
- `cmd_cmplt`  out  1: high once both bytes have been sent; held until the next accepted `snd_cmd`.

## Operation
- Reset values: `TX`=1, `cmd_cmplt`=0, FSM=IDLE, bit and baud counters 0, shift register all ones.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - `snd_cmd`=1 → latch `cmd[7:0]` into a low-byte register.
  - Start the byte transmitter with `cmd[15:8]`.
  - Clear `cmd_cmplt`, go to HIGH.
- HIGH: on tx_done, start the byte transmitter with the latched low byte, go to LOW.
- LOW: on tx_done, set `cmd_cmplt`, go to IDLE.
- `snd_cmd` is ignored in HIGH and LOW. Holding `snd_cmd` high for several cycles starts exactly one transfer. If it is still high when the FSM returns to IDLE, a new transfer starts.
- `cmd` changes after capture have no effect on the transfer in progress.
- Byte frame:
  - 1 start bit (0).
  - 8 data bits, LSB first.
  - 1 stop bit (1).
  - Each bit lasts exactly `BAUD_CNT` clocks.
- Byte transmitter:
  - 10-bit shift register loaded with {1, data, 0}.
  - `TX` is the register LSB, registered, so there are no glitches.
  - Baud counter counts 0..`BAUD_CNT`-1 and shifts at the terminal count.
  - Bit counter counts 0..10; at 10, tx_done pulses for one cycle and the transmitter returns idle with `TX`=1.
- Bytes are back-to-back: the high-byte stop bit is followed directly by the low-byte start bit, with no extra idle bits.
- Async reset mid-transfer aborts immediately: `TX`=1, `cmd_cmplt`=0, FSM=IDLE. No partial resume.

## Timing
- Cycle 0: `snd_cmd` sampled high. From cycle 1: `TX`=0 (start bit).
- High-byte frame occupies 10·`BAUD_CNT` clocks (26040 at default).
- Low-byte start bit begins at most 1 clock after the high-byte stop bit ends.
- `cmd_cmplt` rises within 20·`BAUD_CNT`+3 clocks of the accepted `snd_cmd` (≈52083 at default).
- `cmd_cmplt` falls 1 clock after the next accepted `snd_cmd`.
- Throughput: one command per 20·`BAUD_CNT`+≤3 clocks.

## Structure
- Package `comm_pkg`:
  - FSM state enum {IDLE, HIGH, LOW}.
  - Default `BAUD_CNT` constant (2604).
  - Frame length constant (10 bits).
- Sub-module `uart_tx`:
  - Ports `clk`, `rst_n`, `trmt`, `tx_data`[7:0], `TX`, `tx_done`; parameter `BAUD_CNT`.
  - `comm_master` = FSM + low-byte register + `cmd_cmplt` flop + one `uart_tx`.

## Test plan
- Send 16'hAAAA → `TX` shows:
  - start 0, then bits 0,1,0,1,0,1,0,1, then stop 1;
  - then an identical frame;
  - each bit exactly 2604 clocks wide, sampled mid-bit;
  - `cmd_cmplt`=1 by clock 52083.
- Send 16'h0003 → first frame carries eight 0 data bits; second frame carries 1,1,0,0,0,0,0,0; a receiver model decodes 0x00 then 0x03.
- Hold `snd_cmd` high 2 cycles, then pulse it again mid-HIGH with a different `cmd` → only the first word is sent; `cmd_cmplt` rises once.
- Assert `rst_n`=0 in the middle of the low-byte frame → `TX`=1 and `cmd_cmplt`=0 immediately; after release, a new `snd_cmd` sends a clean full word.
- Back-to-back commands (new `snd_cmd` the cycle after `cmd_cmplt` rises) → `cmd_cmplt` drops 1 clock later; the second word is sent correctly with no inter-word glitch on `TX`.
- Reset checks:
  - `TX`=1 and `cmd_cmplt`=0 throughout reset;
  - `TX` stays 1 indefinitely with `snd_cmd`=0.
